// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_HOLD,
    F_DROP
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          PC_STEP   = 4;

endpackage : fetch_pkg

// File: rtl/fetch_wait_cnt.sv
// Saturating wait-cycle counter; o_hit is high while the count sits at MAX.
module fetch_wait_cnt #(
  parameter  int MAX = 15,
  localparam int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != W'(MAX))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_hit = (r_cnt == W'(MAX));

endmodule : fetch_wait_cnt

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one outstanding req/ack fetch, stall hold and redirect handling.
// Optional wait-timeout flag is built only when FETCH_TIMEOUT_EN is defined.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int              MAX_WAIT = 15
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallF,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] InstrF,
  output logic            InstrF_valid,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F,
  output logic            fetch_busy,
  output logic            fetch_err
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pcf;
  logic [XLEN-1:0] r_instr;
  logic            r_valid;
  logic [XLEN-1:0] r_pend_pc;

  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_busy;

  assign w_target   = PCTargetE & ALIGN_MASK;
  assign w_pc_plus4 = r_pcf + XLEN'(PC_STEP);
  // Request is a pure decode of the state register, so it never glitches.
  assign w_busy     = (r_state == F_REQ) || (r_state == F_DROP);

  // NOTE: sequential state uses non-blocking assignments only, and every
  // register (including pend_pc) has an explicit async reset value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= F_IDLE;
      r_pcf     <= RESET_PC;
      r_instr   <= XLEN'(NOP_INSTR);
      r_valid   <= 1'b0;
      r_pend_pc <= '0;
    end else begin
      unique case (r_state)
        F_IDLE: begin
          r_valid <= 1'b0;
          r_state <= F_REQ;
        end
        F_REQ: begin
          if (imem_ack) begin
            if (PCSrcE) begin
              r_valid <= 1'b0;
              r_pcf   <= w_target;
            end else begin
              r_instr <= imem_rdata;
              r_valid <= 1'b1;
              if (StallF) r_state <= F_HOLD;
              else        r_pcf   <= w_pc_plus4;
            end
          end else begin
            r_valid <= 1'b0;
            if (PCSrcE) begin
              r_pend_pc <= w_target;
              r_state   <= F_DROP;
            end
          end
        end
        F_HOLD: begin
          if (PCSrcE) begin
            r_valid <= 1'b0;
            r_pcf   <= w_target;
            r_state <= F_REQ;
          end else if (!StallF) begin
            r_valid <= 1'b0;
            r_pcf   <= w_pc_plus4;
            r_state <= F_REQ;
          end
        end
        F_DROP: begin
          // The in-flight response belongs to the squashed path; only its ack matters.
          r_valid <= 1'b0;
          if (imem_ack) begin
            r_pcf   <= PCSrcE ? w_target : r_pend_pc;
            r_state <= F_REQ;
          end else if (PCSrcE) begin
            r_pend_pc <= w_target;
          end
        end
        default: r_state <= F_IDLE;
      endcase
    end
  end

`ifdef FETCH_TIMEOUT_EN
  logic w_wait_clr;
  logic w_wait_en;
  logic w_wait_hit;
  logic r_err;

  assign w_wait_clr = !w_busy || imem_ack;
  assign w_wait_en  = w_busy && !imem_ack;

  fetch_wait_cnt #(.MAX(MAX_WAIT)) u_wait_cnt (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (w_wait_clr),
    .i_en  (w_wait_en),
    .o_hit (w_wait_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_err <= 1'b0;
    else if (w_wait_hit) r_err <= 1'b1;
  end

  assign fetch_err = r_err;
`else
  assign fetch_err = 1'b0;
`endif

  assign imem_req     = w_busy;
  assign fetch_busy   = w_busy;
  assign imem_addr    = r_pcf;
  assign PCF          = r_pcf;
  assign PCPlus4F     = w_pc_plus4;
  assign InstrF       = r_instr;
  assign InstrF_valid = r_valid;

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized run against a flag-based model.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        StallF = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] InstrF;
  logic        InstrF_valid;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        fetch_busy;
  logic        fetch_err;

  int n_vec = 0;
  int n_err = 0;

  fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .PCSrcE       (PCSrcE),
    .PCTargetE    (PCTargetE),
    .StallF       (StallF),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .InstrF       (InstrF),
    .InstrF_valid (InstrF_valid),
    .PCF          (PCF),
    .PCPlus4F     (PCPlus4F),
    .fetch_busy   (fetch_busy),
    .fetch_err    (fetch_err)
  );

  always #5 clk = ~clk;

  // Reference model: "started", "holding", "discarding" flags plus PC bookkeeping.
  bit          m_on, m_hold, m_drop, m_valid, m_err;
  logic [31:0] m_pc, m_instr, m_pend_pc;
  int          m_wait;

  task automatic model_reset();
    m_on = 0; m_hold = 0; m_drop = 0; m_valid = 0; m_err = 0;
    m_pc = 32'h0; m_instr = NOP; m_pend_pc = 32'h0; m_wait = 0;
  endtask

  task automatic model_step(input bit ack, input logic [31:0] rd, input bit st,
                            input bit src, input logic [31:0] tgt);
    logic [31:0] t;
    bit busy;
    t    = {tgt[31:2], 2'b00};
    busy = m_on && !m_hold;
`ifdef FETCH_TIMEOUT_EN
    if (m_wait == 15) m_err = 1;
    if (busy && !ack) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
    else              m_wait = 0;
`endif
    if (!m_on) begin
      m_on = 1; m_valid = 0;
    end else if (m_hold) begin
      if (src)      begin m_pc = t;         m_valid = 0; m_hold = 0; end
      else if (!st) begin m_pc = m_pc + 4;  m_valid = 0; m_hold = 0; end
    end else if (m_drop) begin
      m_valid = 0;
      if (ack)      begin m_pc = src ? t : m_pend_pc; m_drop = 0; end
      else if (src) m_pend_pc = t;
    end else if (ack) begin
      if (src) begin m_pc = t; m_valid = 0; end
      else begin
        m_instr = rd; m_valid = 1;
        if (st) m_hold = 1; else m_pc = m_pc + 4;
      end
    end else begin
      m_valid = 0;
      if (src) begin m_pend_pc = t; m_drop = 1; end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, step the model at the rising edge.
  task automatic tick(input bit ack, input logic [31:0] rd, input bit st,
                      input bit src, input logic [31:0] tgt);
    imem_ack = ack; imem_rdata = rd; StallF = st; PCSrcE = src; PCTargetE = tgt;
    @(posedge clk);
    model_step(ack, rd, st, src, tgt);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 0; imem_ack = 0; StallF = 0; PCSrcE = 0; PCTargetE = '0; imem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  task automatic go_to(input logic [31:0] addr);
    int guard;
    apply_reset();
    tick(1, 32'h0, 0, 0, 32'h0);
    guard = 0;
    while (m_pc != addr && guard < 1000) begin
      tick(1, $urandom, 0, 0, 32'h0);
      guard++;
    end
    n_vec++; if (imem_addr !== addr) begin n_err++; $display("FAIL go_to_addr got %h want %h", imem_addr, addr); end
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++; if (imem_req !== 1'b0)     begin n_err++; $display("FAIL rst_req got %b want 0", imem_req); end
    n_vec++; if (PCF !== 32'h0)         begin n_err++; $display("FAIL rst_pcf got %h want 0", PCF); end
    n_vec++; if (InstrF !== NOP)        begin n_err++; $display("FAIL rst_instr got %h want %h", InstrF, NOP); end
    n_vec++; if (InstrF_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", InstrF_valid); end
    n_vec++; if (fetch_busy !== 1'b0)   begin n_err++; $display("FAIL rst_busy got %b want 0", fetch_busy); end
    n_vec++; if (fetch_err !== 1'b0)    begin n_err++; $display("FAIL rst_err got %b want 0", fetch_err); end
    tick(1, 32'hDEAD_BEEF, 0, 0, 32'h0);
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || InstrF_valid !== 1'b0)
      begin n_err++; $display("FAIL idle_ack_ignored got req=%b addr=%h v=%b want 1/0/0", imem_req, imem_addr, InstrF_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] rd;
    for (int i = 1; i <= 4; i++) begin
      rd = $urandom;
      tick(1, rd, 0, 0, 32'h0);
      n_vec++; if (imem_addr !== 32'(4 * i)) begin n_err++; $display("FAIL stream_addr got %h want %h", imem_addr, 32'(4 * i)); end
      n_vec++; if (InstrF_valid !== 1'b1 || InstrF !== rd) begin n_err++; $display("FAIL stream_instr got %b/%h want 1/%h", InstrF_valid, InstrF, rd); end
      n_vec++; if (PCPlus4F !== 32'(4 * i + 4)) begin n_err++; $display("FAIL stream_pc4 got %h want %h", PCPlus4F, 32'(4 * i + 4)); end
    end
  endtask

  task automatic test_wait();
    go_to(32'h10);
    for (int i = 0; i < 3; i++) begin
      tick(0, $urandom, 0, 0, 32'h0);
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || InstrF_valid !== 1'b0)
        begin n_err++; $display("FAIL wait_hold got req=%b addr=%h v=%b want 1/10/0", imem_req, imem_addr, InstrF_valid); end
    end
    tick(1, 32'h0050_0093, 0, 0, 32'h0);
    n_vec++; if (InstrF !== 32'h0050_0093 || InstrF_valid !== 1'b1) begin n_err++; $display("FAIL wait_instr got %h/%b want 00500093/1", InstrF, InstrF_valid); end
    n_vec++; if (imem_addr !== 32'h14) begin n_err++; $display("FAIL wait_next_addr got %h want 14", imem_addr); end
    tick(0, 32'h0, 0, 0, 32'h0);
    n_vec++; if (InstrF_valid !== 1'b0) begin n_err++; $display("FAIL wait_pulse got %b want 0", InstrF_valid); end
  endtask

  task automatic test_stall();
    logic [31:0] rd;
    go_to(32'h20);
    rd = $urandom;
    tick(1, rd, 1, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (imem_req !== 1'b0 || PCF !== 32'h20 || InstrF !== rd || InstrF_valid !== 1'b1)
        begin n_err++; $display("FAIL stall_frozen got req=%b pc=%h i=%h v=%b want 0/20/%h/1", imem_req, PCF, InstrF, InstrF_valid, rd); end
      tick($urandom_range(0, 1), $urandom, (i < 2), 0, 32'h0);
    end
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h24 || InstrF_valid !== 1'b0)
      begin n_err++; $display("FAIL stall_release got req=%b addr=%h v=%b want 1/24/0", imem_req, imem_addr, InstrF_valid); end
  endtask

  task automatic test_redirect_drop();
    go_to(32'h8);
    tick(0, 32'h0, 0, 1, 32'h100);
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || fetch_busy !== 1'b1 || InstrF_valid !== 1'b0)
      begin n_err++; $display("FAIL drop_enter got req=%b addr=%h busy=%b v=%b want 1/8/1/0", imem_req, imem_addr, fetch_busy, InstrF_valid); end
    tick(0, 32'h0, 0, 0, 32'h0);
    tick(1, 32'hBAD0_0001, 0, 0, 32'h0);
    n_vec++; if (imem_addr !== 32'h100 || InstrF_valid !== 1'b0) begin n_err++; $display("FAIL drop_target got %h/%b want 100/0", imem_addr, InstrF_valid); end
    tick(0, 32'h0, 0, 1, 32'h180);
    tick(0, 32'h0, 0, 1, 32'h200);
    n_vec++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL drop_old_addr got %h want 100", imem_addr); end
    tick(1, 32'hBAD0_0002, 0, 0, 32'h0);
    n_vec++; if (imem_addr !== 32'h200 || InstrF_valid !== 1'b0) begin n_err++; $display("FAIL drop_latest got %h/%b want 200/0", imem_addr, InstrF_valid); end
  endtask

  task automatic test_ack_redirect_wrap();
    logic [31:0] old_instr;
    logic [31:0] rd;
    old_instr = m_instr;
    tick(1, 32'hBAD0_0003, 0, 1, 32'h43);
    n_vec++; if (imem_addr !== 32'h40 || InstrF_valid !== 1'b0 || InstrF !== old_instr)
      begin n_err++; $display("FAIL ackredir got addr=%h v=%b i=%h want 40/0/%h", imem_addr, InstrF_valid, InstrF, old_instr); end
    tick(1, 32'h0, 0, 1, 32'hFFFF_FFFC);
    n_vec++; if (PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0) begin n_err++; $display("FAIL wrap_pc4 got %h/%h want fffffffc/0", PCF, PCPlus4F); end
    rd = $urandom;
    tick(1, rd, 0, 0, 32'h0);
    n_vec++; if (PCF !== 32'h0 || InstrF !== rd || InstrF_valid !== 1'b1) begin n_err++; $display("FAIL wrap_pc got %h/%h/%b want 0/%h/1", PCF, InstrF, InstrF_valid, rd); end
  endtask

  task automatic test_random();
    logic [131:0] got, exp;
    bit busy;
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 9) < 4), $urandom, ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 9) == 0), $urandom);
      busy = m_on && !m_hold;
      got  = {imem_req, imem_addr, InstrF, InstrF_valid, PCF, PCPlus4F, fetch_busy, fetch_err};
      exp  = {busy, m_pc, m_instr, m_valid, m_pc, m_pc + 32'd4, busy, m_err};
      n_vec++; if (got !== exp) begin n_err++; $display("FAIL random_cycle%0d got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_timeout();
    go_to(32'h10);
    for (int i = 0; i < 20; i++) begin
      tick(0, 32'h0, 0, 0, 32'h0);
      n_vec++; if (fetch_err !== m_err || imem_req !== 1'b1) begin n_err++; $display("FAIL timeout_cycle%0d got err=%b req=%b want %b/1", i, fetch_err, imem_req, m_err); end
    end
`ifdef FETCH_TIMEOUT_EN
    n_vec++; if (fetch_err !== 1'b1) begin n_err++; $display("FAIL timeout_set got %b want 1", fetch_err); end
    tick(1, 32'h0, 0, 0, 32'h0);
    tick(1, 32'h0, 0, 0, 32'h0);
    n_vec++; if (fetch_err !== 1'b1) begin n_err++; $display("FAIL timeout_sticky got %b want 1", fetch_err); end
`else
    n_vec++; if (fetch_err !== 1'b0) begin n_err++; $display("FAIL timeout_tied got %b want 0", fetch_err); end
`endif
  endtask

  task automatic test_async_reset();
    go_to(32'h10);
    repeat (5) tick(0, 32'h0, 0, 0, 32'h0);
    #2 reset = 0;
    #1;
    n_vec++; if (imem_req !== 1'b0 || PCF !== 32'h0 || InstrF !== NOP || InstrF_valid !== 1'b0 || fetch_busy !== 1'b0 || fetch_err !== 1'b0)
      begin n_err++; $display("FAIL async_rst got req=%b pc=%h i=%h v=%b busy=%b err=%b", imem_req, PCF, InstrF, InstrF_valid, fetch_busy, fetch_err); end
    model_reset();
    @(negedge clk);
    reset = 1;
    tick(0, 32'h0, 0, 0, 32'h0);
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL async_restart got %b/%h want 1/0", imem_req, imem_addr); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_wait();
    test_stall();
    test_redirect_drop();
    test_ack_redirect_wrap();
    test_random();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_fetch_ctrl
